// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - register-file write-back arbiter with ALU queue and pending scoreboard
module write_back_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_WIDTH-1:0]         alu_dest,
  input  logic [DATA_WIDTH-1:0]         alu_data,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [ADDR_WIDTH-1:0]         mem_dest,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  output logic                          writeEnable,
  output logic [ADDR_WIDTH-1:0]         writeReg,
  output logic [DATA_WIDTH-1:0]         writeData,
  output logic [(1<<ADDR_WIDTH)-1:0]    pending,
  output logic [$clog2(DEPTH):0]        queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] dest_q [DEPTH];
  logic [ADDR_WIDTH-1:0] dest_d [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic alu_acc, non_empty, pop, bypass, push;

  assign alu_ready   = (count_q < CNT_W'(DEPTH));
  assign alu_acc     = alu_valid && alu_ready;
  assign non_empty   = (count_q != '0);
  assign pop         = !mem_valid && non_empty;
  assign bypass      = !mem_valid && !non_empty && alu_acc;
  assign push        = alu_acc && !bypass;

  assign writeEnable = we_q;
  assign writeReg    = wreg_q;
  assign writeData   = wdata_q;
  assign queue_count = count_q;

  always_comb begin
    valid_d = valid_q;
    dest_d  = dest_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;

    if (mem_valid) begin
      we_d    = 1'b1;
      wreg_d  = mem_dest;
      wdata_d = mem_data;
      // A load is younger than everything already queued, so older writes to its dest are dead.
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && dest_q[i] == mem_dest) valid_d[i] = 1'b0;
      end
    end else if (non_empty) begin
      we_d            = valid_q[head_q];
      wreg_d          = dest_q[head_q];
      wdata_d         = data_q[head_q];
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end else if (alu_acc) begin
      we_d    = 1'b1;
      wreg_d  = alu_dest;
      wdata_d = alu_data;
    end

    if (push) begin
      valid_d[tail_q] = 1'b1;
      dest_d[tail_q]  = alu_dest;
      data_d[tail_q]  = alu_data;
      tail_d          = tail_q + PTR_W'(1);
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) pending[dest_q[i]] = 1'b1;
    end
    if (we_q) pending[wreg_q] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_q[i] <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      wreg_q  <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
